// File: rtl/vga_fb_pixel_engine.sv
// vga_fb_pixel_engine: double-buffered, pixel-replicating framebuffer with an optional
// 256-entry palette, turning timing-generator coordinates into registered RGB.
//
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   x_pos, y_pos          current pixel column / line
//   display_enable        active video from the timing generator
//   pal_mode              0 = direct colour, 1 = palette (taken at frame commit)
//   swap_req              one-cycle request to exchange front/back buffers
//   wr_valid/wr_ready     host write handshake
//   wr_sel                0 = back framebuffer, 1 = palette
//   wr_addr, wr_data      write word address and data
//   wr_err                pulse one cycle after an out-of-range framebuffer write
//   red, green, blue      registered colour, 3 cycles after the coordinates
//   de_out                display_enable aligned with the colour
//   front_buf             index of the displayed buffer
//   swap_done             pulse when a swap commits
module vga_fb_pixel_engine #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              x_pos,
  input  logic [9:0]              y_pos,
  input  logic                    display_enable,
  input  logic                    pal_mode,
  input  logic                    swap_req,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    wr_sel,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [3*COLOR_BITS-1:0] wr_data,
  output logic                    wr_err,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    de_out,
  output logic                    front_buf,
  output logic                    swap_done
);

  localparam int unsigned PW        = 3 * COLOR_BITS;
  localparam int unsigned FB_W      = H_RES >> SCALE_LOG2;
  localparam int unsigned FB_H      = V_RES >> SCALE_LOG2;
  localparam int unsigned FB_SIZE   = FB_W * FB_H;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_W;

  // Storage (never reset)
  logic [PW-1:0] fb0_mem [MEM_DEPTH];
  logic [PW-1:0] fb1_mem [MEM_DEPTH];
  logic [PW-1:0] pal_mem [256];

  // Control state
  logic       front_buf_q;
  logic       swap_pending_q;
  logic       pal_mode_q;
  logic       swap_done_q;
  logic       wr_err_q;
  logic       ready_q;
  logic [9:0] y_prev_q;

  // Read pipeline
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_buf_q;
  logic              rng1_q;
  logic              rng2_q;
  logic [2:0]        de_q;
  logic [PW-1:0]     word_q;
  logic [PW-1:0]     rgb_q;

  // Combinational
  logic              commit;
  logic              swap_fire;
  logic              accept;
  logic              oob;
  logic              fb_we;
  logic              pal_we;
  logic [9:0]        fx;
  logic [9:0]        fy;
  logic [31:0]       lin_addr;
  logic              in_range_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        pal_idx;

  always_comb begin
    // Vertical blank starts on the first line at V_RES; y_prev_q makes it a one-shot.
    commit    = (32'(y_pos) == V_RES) && (32'(y_prev_q) != V_RES);
    swap_fire = commit & swap_pending_q;
    // Writes stall only in the swap cycle so the back-buffer target is never ambiguous.
    wr_ready  = ready_q & ~swap_fire;
    accept    = wr_valid & wr_ready;
    oob       = 32'(wr_addr) >= FB_SIZE;
    fb_we     = accept & ~wr_sel & ~oob;
    pal_we    = accept & wr_sel;

    fx         = x_pos >> SCALE_LOG2;
    fy         = y_pos >> SCALE_LOG2;
    lin_addr   = 32'(fy) * FB_W + 32'(fx);
    in_range_d = display_enable && (32'(x_pos) < H_RES) && (32'(y_pos) < V_RES);
    // Off-screen coordinates read word 0; the result is blanked anyway.
    addr_d     = in_range_d ? lin_addr[ADDR_W-1:0] : '0;

    // Truncates wide pixel words, zero-extends narrow ones.
    pal_idx = 8'(word_q);
  end

  // Memory ports and the data-only S2 register
  always_ff @(posedge clk) begin
    if (fb_we && front_buf_q)  fb0_mem[wr_addr] <= wr_data;
    if (fb_we && !front_buf_q) fb1_mem[wr_addr] <= wr_data;
    if (pal_we)                pal_mem[wr_addr[7:0]] <= wr_data;
    word_q <= rd_buf_q ? fb1_mem[rd_addr_q] : fb0_mem[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_buf_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      pal_mode_q     <= 1'b0;
      swap_done_q    <= 1'b0;
      wr_err_q       <= 1'b0;
      ready_q        <= 1'b0;
      y_prev_q       <= '0;
      rd_addr_q      <= '0;
      rd_buf_q       <= 1'b0;
      rng1_q         <= 1'b0;
      rng2_q         <= 1'b0;
      de_q           <= '0;
      rgb_q          <= '0;
    end else begin
      ready_q  <= 1'b1;
      y_prev_q <= y_pos;
      wr_err_q <= accept & ~wr_sel & oob;

      if (commit) pal_mode_q <= pal_mode;

      swap_done_q <= swap_fire;
      if (swap_fire) begin
        front_buf_q    <= ~front_buf_q;
        // A request arriving in the commit cycle is kept for the next frame.
        swap_pending_q <= swap_req;
      end else if (swap_req) begin
        swap_pending_q <= 1'b1;
      end

      // S1
      rd_addr_q <= addr_d;
      rd_buf_q  <= front_buf_q;
      rng1_q    <= in_range_d;
      // S2 (word_q in the memory block)
      rng2_q    <= rng1_q;
      // S3: palette lookup is a synchronous read from word_q, matching direct latency
      de_q      <= {de_q[1:0], display_enable};
      if (!rng2_q)         rgb_q <= '0;
      else if (pal_mode_q) rgb_q <= pal_mem[pal_idx];
      else                 rgb_q <= word_q;
    end
  end

  assign red       = rgb_q[PW-1 -: COLOR_BITS];
  assign green     = rgb_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign blue      = rgb_q[COLOR_BITS-1:0];
  assign de_out    = de_q[2];
  assign front_buf = front_buf_q;
  assign swap_done = swap_done_q;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_vga_fb_pixel_engine.sv
// Directed bench for vga_fb_pixel_engine at default parameters (640x480, scale 2, 12-bit).
module tb_vga_fb_pixel_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  x_pos = '0;
  logic [9:0]  y_pos = '0;
  logic        display_enable = 1'b0;
  logic        pal_mode = 1'b0;
  logic        swap_req = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic        wr_sel = 1'b0;
  logic [16:0] wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_err;
  logic [3:0]  red, green, blue;
  logic        de_out;
  logic        front_buf;
  logic        swap_done;
  logic [11:0] rgb;

  int checks = 0;
  int failures = 0;

  assign rgb = {red, green, blue};

  always #5 clk = ~clk;

  vga_fb_pixel_engine dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .x_pos          (x_pos),
    .y_pos          (y_pos),
    .display_enable (display_enable),
    .pal_mode       (pal_mode),
    .swap_req       (swap_req),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_sel         (wr_sel),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_err         (wr_err),
    .red            (red),
    .green          (green),
    .blue           (blue),
    .de_out         (de_out),
    .front_buf      (front_buf),
    .swap_done      (swap_done)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a write and hold it until accepted (bounded).
  task automatic host_write(input logic sel, input logic [16:0] a, input logic [11:0] d);
    int n;
    n = 0;
    wr_sel   = sel;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!wr_ready && n < 8) begin
      step();
      n++;
    end
    if (n == 8) check_eq("wr_ready_wait", wr_ready, 1);
    step();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  // Returns just after the commit edge with y_pos still at V_RES.
  task automatic commit_frame(input logic req_at_commit);
    display_enable = 1'b0;
    y_pos = 10'd479;
    step();
    y_pos = 10'd480;
    swap_req = req_at_commit;
    step();
    swap_req = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input logic de);
    x_pos = 10'(x);
    y_pos = 10'(y);
    display_enable = de;
    step();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int pulses;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_rgb", rgb, 0);
    check_eq("rst_de", de_out, 0);
    check_eq("rst_front", front_buf, 0);
    check_eq("rst_ready", wr_ready, 0);
    #18 rst_n = 1'b1;
    check_eq("ready_before_edge", wr_ready, 0);
    step();
    check_eq("ready_after_edge", wr_ready, 1);

    // Direct colour through buffer 1 with 2x replication
    host_write(1'b0, 17'd0, 12'hF00);
    host_write(1'b0, 17'd1, 12'h0F0);
    pulse_swap();
    commit_frame(1'b0);
    check_eq("swap1_done", swap_done, 1);
    check_eq("swap1_front", front_buf, 1);
    step();
    check_eq("swap1_done_clr", swap_done, 0);
    x_pos = 10'd0;
    y_pos = 10'd0;
    display_enable = 1'b1;
    step();
    step();
    check_eq("lat2_de", de_out, 0);
    check_eq("lat2_rgb", rgb, 0);
    step();
    check_eq("lat3_de", de_out, 1);
    check_eq("x0", rgb, 12'hF00);
    pix(1, 0, 1'b1);
    check_eq("x1", rgb, 12'hF00);
    pix(2, 0, 1'b1);
    check_eq("x2", rgb, 12'h0F0);
    pix(3, 1, 1'b1);
    check_eq("x3y1", rgb, 12'h0F0);

    // Palette mode through buffer 0
    host_write(1'b1, 17'd5, 12'h00F);
    host_write(1'b0, 17'd0, 12'h005);
    host_write(1'b0, 17'd2, 12'h321);
    pulse_swap();
    pal_mode = 1'b1;
    commit_frame(1'b0);
    check_eq("swap2_front", front_buf, 0);
    pix(0, 0, 1'b1);
    check_eq("pal_x0", rgb, 12'h00F);
    pal_mode = 1'b0;
    pix(1, 0, 1'b1);
    check_eq("pal_hold", rgb, 12'h00F);
    commit_frame(1'b0);
    check_eq("noswap_done", swap_done, 0);
    check_eq("noswap_front", front_buf, 0);
    pix(0, 0, 1'b1);
    check_eq("direct_again", rgb, 12'h005);

    // Merged requests, and a request in the commit cycle
    pulse_swap();
    step();
    pulse_swap();
    display_enable = 1'b0;
    y_pos = 10'd479;
    step();
    y_pos = 10'd480;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(swap_done);
    end
    check_eq("merged_pulses", pulses, 1);
    check_eq("merged_front", front_buf, 1);
    commit_frame(1'b0);
    check_eq("idle_done", swap_done, 0);
    check_eq("idle_front", front_buf, 1);
    pulse_swap();
    commit_frame(1'b1);
    check_eq("reqcommit_done", swap_done, 1);
    check_eq("reqcommit_front", front_buf, 0);
    commit_frame(1'b0);
    check_eq("carry_done", swap_done, 1);
    check_eq("carry_front", front_buf, 1);

    // Out-of-range write, then a write held across a swap commit
    host_write(1'b0, 17'd76800, 12'hFFF);
    check_eq("oob_err", wr_err, 1);
    step();
    check_eq("oob_err_clr", wr_err, 0);
    host_write(1'b0, 17'd3, 12'h456);
    check_eq("inrange_err", wr_err, 0);
    pulse_swap();
    y_pos = 10'd479;
    step();
    y_pos = 10'd480;
    wr_sel = 1'b0;
    wr_addr = 17'd2;
    wr_data = 12'hABC;
    wr_valid = 1'b1;
    #1;
    check_eq("commit_ready", wr_ready, 0);
    step();
    check_eq("hold_swap_done", swap_done, 1);
    check_eq("hold_front", front_buf, 0);
    check_eq("post_commit_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    host_write(1'b0, 17'd350, 12'h777);
    pulse_swap();
    commit_frame(1'b0);
    check_eq("hold_front2", front_buf, 1);
    pix(4, 0, 1'b1);
    check_eq("held_data", rgb, 12'hABC);

    // Blanking
    pix(0, 0, 1'b0);
    check_eq("blank_de0_rgb", rgb, 0);
    check_eq("blank_de0_de", de_out, 0);
    pix(700, 0, 1'b1);
    check_eq("blank_x700_rgb", rgb, 0);
    check_eq("blank_x700_de", de_out, 1);
    pix(0, 0, 1'b1);
    check_eq("unblank", rgb, 12'hF00);

    // Asynchronous reset mid-line
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rgb", rgb, 0);
    check_eq("mid_rst_de", de_out, 0);
    check_eq("mid_rst_front", front_buf, 0);
    check_eq("mid_rst_ready", wr_ready, 0);
    #3 rst_n = 1'b1;
    step();
    pix(4, 0, 1'b1);
    check_eq("kept_buf0_a2", rgb, 12'h321);
    pix(0, 0, 1'b1);
    check_eq("kept_buf0_a0", rgb, 12'h005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
